// File: rtl/uart_prog_loader_pkg.sv
// Shared types and constants for the UART program loader and its byte receiver.
package uart_prog_loader_pkg;

    localparam int   DATA_BITS            = 8;
    localparam logic STOP_LEVEL           = 1'b1;
    localparam int   DEFAULT_CLKS_PER_BIT = 104;

    // Loader states: image framing is one length byte followed by the payload.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_LEN,
        ST_LOAD,
        ST_DONE,
        ST_ERROR
    } loader_state_e;

    // Receiver states: one 8N1 character from start edge to stop-bit sample.
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_prog_loader_rx.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-bit sampling timer, LSB-first shifter.
// Output handshake: byte_valid_o / byte_err_o are single-cycle strobes with no
// backpressure; data_o is stable while byte_valid_o is high and the consumer
// must take it in that cycle.
module uart_rx_byte
    import uart_prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic       byte_valid_o,
    output logic       byte_err_o,
    output logic [7:0] data_o
);

    localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_valid_q, byte_valid_d;
    logic             byte_err_q, byte_err_d;
    logic             rx_meta_q, rx_sync_q, rx_prev_q;

    // Synchronizer, edge-history flop and receiver state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            state_q      <= RX_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            byte_err_q   <= 1'b0;
        end else begin
            rx_meta_q    <= rx_i;
            rx_sync_q    <= rx_meta_q;
            rx_prev_q    <= rx_sync_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            byte_err_q   <= byte_err_d;
        end
    end

    // Bit timing: re-check start at half a bit, then sample each bit one period apart.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        byte_err_d   = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    // A start bit that is high again at mid-bit was only a glitch.
                    state_d   = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    if (rx_sync_q == STOP_LEVEL) begin
                        byte_valid_d = 1'b1;
                    end else begin
                        byte_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_valid_o = byte_valid_q;
    assign byte_err_o   = byte_err_q;
    assign data_o       = shift_q;

endmodule

// File: rtl/uart_prog_loader.sv
// Boot loader: receives a length-prefixed image over UART and writes it to program memory.
module uart_prog_loader
    import uart_prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT  = DEFAULT_CLKS_PER_BIT,
    parameter int ADDR_W        = 8,
    parameter bit BOOT_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_rx,
    input  logic              start,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              frame_err
);

    localparam loader_state_e RESET_STATE = BOOT_ON_RESET ? ST_WAIT_LEN : ST_IDLE;

    logic       rx_valid, rx_err;
    logic [7:0] rx_data;

    loader_state_e     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [8:0]        remain_q, remain_d;
    logic              we_q, we_d;
    logic [7:0]        wdata_q, wdata_d;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk_i        (clk),
        .rst_i        (rst),
        .rx_i         (uart_rx),
        .byte_valid_o (rx_valid),
        .byte_err_o   (rx_err),
        .data_o       (rx_data)
    );

    // Loader state, write address, remaining-byte count and registered write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RESET_STATE;
            addr_q   <= '0;
            remain_q <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
        end
    end

    // Next-state: start only acts from IDLE/DONE/ERROR; bytes only count in WAIT_LEN/LOAD.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        we_d     = 1'b0;
        wdata_d  = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_WAIT_LEN;
            end
            ST_WAIT_LEN: begin
                if (rx_valid) begin
                    remain_d = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                    addr_d   = '0;
                    state_d  = ST_LOAD;
                end else if (rx_err) begin
                    state_d = ST_ERROR;
                end
            end
            ST_LOAD: begin
                // The strobe cycle advances the address; the last one finishes the image.
                if (we_q) begin
                    addr_d   = addr_q + 1'b1;
                    remain_d = remain_q - 1'b1;
                    if (remain_q == 9'd1) state_d = ST_DONE;
                end
                if (rx_valid) begin
                    we_d    = 1'b1;
                    wdata_d = rx_data;
                end else if (rx_err) begin
                    state_d = ST_ERROR;
                end
            end
            ST_DONE: begin
                if (start) state_d = ST_WAIT_LEN;
            end
            ST_ERROR: begin
                if (start) state_d = ST_WAIT_LEN;
            end
            default: state_d = RESET_STATE;
        endcase
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_hold  = (state_q == ST_WAIT_LEN) || (state_q == ST_LOAD) || (state_q == ST_ERROR);
    assign load_done = (state_q == ST_DONE);
    assign frame_err = (state_q == ST_ERROR);

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: one boot-on-reset instance and one idle-on-reset instance.
module tb_uart_prog_loader;

    localparam int CPB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance with BOOT_ON_RESET=1
    logic       rst, rx, start;
    logic       we, hold, done, ferr;
    logic [7:0] addr, wdata;

    // Instance with BOOT_ON_RESET=0
    logic       rst0, rx0, start0;
    logic       we0, hold0, done0, ferr0;
    logic [7:0] addr0, wdata0;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_q[$];
    logic [15:0] exp0_q[$];

    uart_prog_loader #(
        .CLKS_PER_BIT(CPB), .ADDR_W(8), .BOOT_ON_RESET(1'b1)
    ) u_dut (
        .clk(clk), .rst(rst), .uart_rx(rx), .start(start),
        .mem_we(we), .mem_addr(addr), .mem_wdata(wdata),
        .cpu_hold(hold), .load_done(done), .frame_err(ferr)
    );

    uart_prog_loader #(
        .CLKS_PER_BIT(CPB), .ADDR_W(8), .BOOT_ON_RESET(1'b0)
    ) u_dut0 (
        .clk(clk), .rst(rst0), .uart_rx(rx0), .start(start0),
        .mem_we(we0), .mem_addr(addr0), .mem_wdata(wdata0),
        .cpu_hold(hold0), .load_done(done0), .frame_err(ferr0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Clock/drive helper: inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) rx0 = v;
        else     rx  = v;
    endtask

    task automatic send_byte(input bit sel, input logic [7:0] b, input logic stop);
        drive(sel, 1'b0);
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            drive(sel, b[i]);
            repeat (CPB) tick();
        end
        drive(sel, stop);
        repeat (CPB) tick();
        drive(sel, 1'b1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Scoreboard monitor for the boot-on-reset instance.
    always @(negedge clk) begin
        logic [15:0] e;
        if (we === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: addr=0x%0h data=0x%0h, expected no write", addr, wdata);
            end else begin
                e = exp_q.pop_front();
                check("write", {16'h0, addr, wdata}, {16'h0, e});
            end
        end
    end

    // Scoreboard monitor for the idle-on-reset instance.
    always @(negedge clk) begin
        logic [15:0] e;
        if (we0 === 1'b1) begin
            if (exp0_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write0: addr=0x%0h data=0x%0h, expected no write", addr0, wdata0);
            end else begin
                e = exp0_q.pop_front();
                check("write0", {16'h0, addr0, wdata0}, {16'h0, e});
            end
        end
    end

    initial begin
        rst = 1'b1; rst0 = 1'b1; rx = 1'b1; rx0 = 1'b1; start = 1'b0; start0 = 1'b0;
        repeat (3) tick();
        rst = 1'b0; rst0 = 1'b0;

        // Reset values
        check("rst_we",      {31'h0, we},    32'h0);
        check("rst_addr",    {24'h0, addr},  32'h0);
        check("rst_wdata",   {24'h0, wdata}, 32'h0);
        check("rst_done",    {31'h0, done},  32'h0);
        check("rst_ferr",    {31'h0, ferr},  32'h0);
        check("rst_hold",    {31'h0, hold},  32'h1);
        check("rst_hold0",   {31'h0, hold0}, 32'h0);
        check("rst_done0",   {31'h0, done0}, 32'h0);

        // Three-byte image, then DONE two cycles after the last stop sample
        exp_q.push_back(16'h00A1);
        exp_q.push_back(16'h01B2);
        exp_q.push_back(16'h02C3);
        send_byte(0, 8'h03, 1'b1);
        send_byte(0, 8'hA1, 1'b1);
        send_byte(0, 8'hB2, 1'b1);
        send_byte(0, 8'hC3, 1'b1);
        tick();
        tick();
        check("t1_done_early", {31'h0, done}, 32'h0);
        check("t1_hold_early", {31'h0, hold}, 32'h1);
        tick();
        check("t1_done", {31'h0, done}, 32'h1);
        check("t1_hold", {31'h0, hold}, 32'h0);
        check("t1_addr", {24'h0, addr}, 32'h3);

        // Length 0 means 256 bytes; address wraps to 0
        pulse_start();
        check("t2_hold_wait", {31'h0, hold}, 32'h1);
        check("t2_done_clr",  {31'h0, done}, 32'h0);
        for (int i = 0; i < 256; i++) exp_q.push_back({i[7:0], i[7:0]});
        send_byte(0, 8'h00, 1'b1);
        for (int i = 0; i < 256; i++) send_byte(0, i[7:0], 1'b1);
        repeat (3) tick();
        check("t2_done", {31'h0, done}, 32'h1);
        check("t2_addr", {24'h0, addr}, 32'h0);
        check("t2_hold", {31'h0, hold}, 32'h0);

        // Bad stop bit mid-load
        pulse_start();
        exp_q.push_back(16'h0055);
        send_byte(0, 8'h02, 1'b1);
        send_byte(0, 8'h55, 1'b1);
        send_byte(0, 8'hAA, 1'b0);
        repeat (2 * CPB) tick();
        check("t3_ferr", {31'h0, ferr}, 32'h1);
        check("t3_hold", {31'h0, hold}, 32'h1);
        check("t3_addr", {24'h0, addr}, 32'h1);
        send_byte(0, 8'h99, 1'b1);
        repeat (2 * CPB) tick();
        check("t3_ferr_stays", {31'h0, ferr}, 32'h1);
        pulse_start();
        check("t3_ferr_clr", {31'h0, ferr}, 32'h0);
        check("t3_hold_wait", {31'h0, hold}, 32'h1);

        // One-cycle glitch on the line while waiting for a length
        rx = 1'b0;
        tick();
        rx = 1'b1;
        repeat (4 * CPB) tick();
        check("t4_hold", {31'h0, hold}, 32'h1);
        check("t4_done", {31'h0, done}, 32'h0);
        check("t4_ferr", {31'h0, ferr}, 32'h0);

        // Reset after one of four payload bytes, then a fresh one-byte image
        exp_q.push_back(16'h0011);
        send_byte(0, 8'h04, 1'b1);
        send_byte(0, 8'h11, 1'b1);
        repeat (3) tick();
        check("t5_addr_before", {24'h0, addr}, 32'h1);
        rst = 1'b1;
        tick();
        check("t5_hold", {31'h0, hold}, 32'h1);
        check("t5_addr", {24'h0, addr}, 32'h0);
        check("t5_done", {31'h0, done}, 32'h0);
        rst = 1'b0;
        exp_q.push_back(16'h007E);
        send_byte(0, 8'h01, 1'b1);
        send_byte(0, 8'h7E, 1'b1);
        repeat (3) tick();
        check("t5_done_after", {31'h0, done}, 32'h1);
        check("t5_hold_after", {31'h0, hold}, 32'h0);

        // Idle-on-reset instance ignores bytes until start
        send_byte(1, 8'h01, 1'b1);
        send_byte(1, 8'h42, 1'b1);
        repeat (3) tick();
        check("t6_hold_idle", {31'h0, hold0}, 32'h0);
        check("t6_done_idle", {31'h0, done0}, 32'h0);
        start0 = 1'b1;
        check("t6_hold_pre", {31'h0, hold0}, 32'h0);
        tick();
        start0 = 1'b0;
        check("t6_hold_rise", {31'h0, hold0}, 32'h1);
        exp0_q.push_back(16'h0042);
        send_byte(1, 8'h01, 1'b1);
        send_byte(1, 8'h42, 1'b1);
        repeat (3) tick();
        check("t6_done", {31'h0, done0}, 32'h1);
        check("t6_hold", {31'h0, hold0}, 32'h0);

        // All expected writes consumed
        repeat (5) tick();
        check("queue_empty",  exp_q.size(),  32'h0);
        check("queue0_empty", exp0_q.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Boot-time program loader upstream of the processor's program memory.
- Receives a program image over a serial UART line and writes it byte-by-byte into program memory.
- Holds the processor stalled (cpu_hold) until the image is complete.
- Image framing: one length byte N (0 means 256), then N payload bytes written to addresses 0..N-1.

Parameters:
CLKS_PER_BIT, 104, clk cycles per UART bit (minimum 4)
ADDR_W, 8, program memory address width
BOOT_ON_RESET, 1, 1 = enter WAIT_LEN after reset; 0 = enter IDLE

Ports:
clk  input  1  system clock, all logic rising-edge
rst  input  1  synchronous active-high reset
uart_rx  input  1  asynchronous serial input, idle high, 8N1, LSB first
start  input  1  one-cycle request to (re)load the program image
mem_we  output  1  program-memory write strobe, one cycle per byte
mem_addr  output  ADDR_W  write address
mem_wdata  output  8  write data
cpu_hold  output  1  high keeps the processor stalled
load_done  output  1  high once a full image has been written
frame_err  output  1  high after a bad stop bit, until start or rst

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, rst).
- Reset values:
  - mem_we=0, mem_addr=0, mem_wdata=0, load_done=0, frame_err=0.
  - cpu_hold=BOOT_ON_RESET.
  - Receiver idle; both sync flops set to 1.
- Receiver (sub-module):
  - uart_rx passes through a 2-flop synchronizer.
  - A synchronized 1->0 transition starts the bit counter.
  - At CLKS_PER_BIT/2 (integer division) the start bit is re-sampled. If it is high, the event is a glitch: return to idle with no output.
  - Data bits are sampled every CLKS_PER_BIT cycles thereafter, LSB first.
  - Stop bit is sampled one CLKS_PER_BIT later:
    - High: byte_valid pulses for 1 cycle with the data.
    - Low: byte_err pulses for 1 cycle.
  - The receiver returns to idle and accepts the next start edge on the cycle after the stop-bit sample.
- Loader FSM states: IDLE, WAIT_LEN, LOAD, DONE, ERROR.
  - IDLE: cpu_hold=0, load_done=0. Received bytes are ignored. start -> WAIT_LEN.
  - WAIT_LEN: cpu_hold=1.
    - byte_valid: latch remaining = (byte==0 ? 256 : byte), mem_addr=0 -> LOAD.
    - byte_err -> ERROR.
  - LOAD: cpu_hold=1. Each byte_valid causes, on the next cycle:
    - mem_we=1 for exactly 1 cycle, with mem_wdata=byte and mem_addr=current address.
    - After the strobe, the address increments (mod 2^ADDR_W) and remaining decrements.
    - When remaining reaches 0 after a write -> DONE on the cycle after the final mem_we.
    - byte_err -> ERROR.
  - DONE: cpu_hold=0, load_done=1. start -> WAIT_LEN, which clears load_done the same cycle.
  - ERROR: cpu_hold=1, frame_err=1, no writes. start -> WAIT_LEN, which clears frame_err.
- start while in WAIT_LEN or LOAD is ignored; the load in progress continues.
- byte_valid and start in the same cycle: the FSM transition on start takes priority. The byte is dropped unless the FSM was already in WAIT_LEN or LOAD.
- With ADDR_W=8 and N=0, 256 bytes are written to 0x00..0xFF, and mem_addr wraps to 0x00 at DONE.
- rst mid-byte or mid-load aborts immediately:
  - Partially written memory is not rolled back.
  - Outputs return to reset values on the next edge.
- Latency: byte_valid to mem_we is 1 cycle. Final stop-bit sample to cpu_hold falling is 2 cycles.

Decomposition:
- Shared package:
  - Loader state enum: IDLE, WAIT_LEN, LOAD, DONE, ERROR.
  - UART constants: DATA_BITS=8, STOP_LEVEL=1.
  - Default CLKS_PER_BIT.
- One sub-module, uart_rx_byte: synchronizer, bit timer and shift register. Outputs byte_valid, byte_err and data[7:0].
- The loader FSM and address/count registers stay in uart_prog_loader.

Test Plan:
1. CLKS_PER_BIT=4, BOOT_ON_RESET=1; after rst send 0x03, 0xA1, 0xB2, 0xC3 -> three mem_we pulses: (0x00,0xA1), (0x01,0xB2), (0x02,0xC3). Then load_done=1 and cpu_hold=0 two cycles after the last stop sample.
2. Send 0x00 then 256 bytes of value i -> 256 writes, addr 0x00..0xFF with data==addr. mem_addr=0x00 and load_done=1 at the end.
3. Send 0x02, 0x55, then a byte whose stop bit is held low -> one write (0x00,0x55), then frame_err=1 and cpu_hold=1 with no further writes. A start pulse then clears frame_err and enters WAIT_LEN.
4. Pull uart_rx low for 1 cycle only (glitch shorter than CLKS_PER_BIT/2) -> no byte_valid, no write, FSM state unchanged.
5. Assert rst after 1 of 4 payload bytes -> cpu_hold=1, mem_addr=0, load_done=0 on the next cycle. A fresh 0x01, 0x7E image then writes (0x00,0x7E) and completes.
6. BOOT_ON_RESET=0: bytes sent after rst -> no writes and cpu_hold=0. Then pulse start, send 0x01, 0x42 -> cpu_hold rises the cycle after start, write (0x00,0x42), then DONE.
